camera_frame_writer: RTL and testbench
======================================

// Module: camera_frame_writer
//
// PURPOSE
//  Producer side of the camera frame buffer.
//  - Samples a DVP camera bus (pclk/href/vsync/data[7:0], YUYV 4:2:2) on clk.
//  - Keeps the Y byte of each pixel, binarizes it against THRESH, packs 8 px/byte MSB-first.
//  - Writes the bytes to SPRAM at addresses 0..BYTES-1.
//  - Raises buffer_ready for the SPI readout slave; holds it until frame_read_complete.
//
// PARAMETERS
//  IMG_W   320                 active pixels per line (2*IMG_W bytes per href)
//  IMG_H   240                 active lines per frame
//  THRESH  8'd128              Y >= THRESH -> bit 1 (white), else 0
//  BYTES   IMG_W*IMG_H/8=9600  packed bytes per frame
//
// PORTS
//  clk                  in   1   system clock, 48 MHz
//  nreset               in   1   async active-low reset
//  cam_pclk             in   1   camera pixel clock, async, <= 12 MHz
//  cam_href             in   1   line valid, async, active high
//  cam_vsync            in   1   frame sync, async, high during vertical blanking
//  cam_data             in   8   camera data, valid at cam_pclk rising
//  spram_wr_addr        out  17  byte write address, 0..BYTES-1
//  spram_wr_data        out  8   packed byte, px0 in bit7
//  spram_wr_en          out  1   one-clk write strobe
//  buffer_ready         out  1   complete frame stored in SPRAM
//  frame_read_complete  in   1   one-clk pulse from SPI slave: frame consumed
//  frame_drop           out  1   one-clk pulse: short frame discarded
//
// BEHAVIOUR
//  Reset: all outputs 0; state WAIT_VS; counters 0.
//    Async assert; deassert takes effect at the next clk edge.
//  Sync: pclk/href/vsync/data pass through 2 clk flops, then 1 history flop.
//    data is delayed equally with pclk, so a sample matches its pclk edge.
//    pclk_rise = s2 & ~s3. vs_fall/vs_rise are edges of synced vsync.
//  FSM:
//    WAIT_VS: wait for vs_rise, which guarantees a full frame follows -> WAIT_START.
//    WAIT_START: vs_fall -> CAPTURE. Clear byte_cnt, bit_cnt and phase.
//    CAPTURE:
//      On pclk_rise with href=1, phase toggles. phase resets to 0 on each href rising edge.
//      phase 0 = Y byte: shift (Y>=THRESH) into pack_reg; bit_cnt++.
//      On bit_cnt 7->0, if byte_cnt<BYTES: next clk spram_wr_en=1,
//        wr_addr=byte_cnt, wr_data=packed byte; then byte_cnt++.
//      Bytes beyond BYTES are dropped silently (no write, no address wrap).
//      On vs_rise: byte_cnt==BYTES -> READY. Otherwise pulse frame_drop -> WAIT_START.
//        A dropped frame is not retried mid-frame.
//      A partial pack_reg (bit_cnt!=0) at vs_rise is discarded.
//    READY: buffer_ready=1; camera traffic ignored; no writes.
//      frame_read_complete -> clear buffer_ready next clk -> WAIT_VS.
//      Capture restarts at a fresh frame boundary only.
//  frame_read_complete outside READY is ignored.
//  If a pclk_rise and frame_read_complete land on the same clk in READY,
//    the pulse wins; the sample is ignored.
//  Latency: 8th Y sample edge to spram_wr_en = 4 clk (3 sync + 1 reg).
//  Constraint: pclk period >= 4 clk and pclk high/low >= 2 clk each; otherwise edges are lost.
//  byte_cnt is 17 bits; the compare uses BYTES at full width.
//
// CONFIGURATION
//  FRAME_STATS_EN
//    Defined: adds output white_count[16:0]. Counts 1-bits written this frame.
//      Latched on the READY transition; cleared on reset only.
//      The working counter clears at WAIT_START->CAPTURE.
//    Undefined: port and counter absent; all other behaviour identical.
//
// TESTING
//  1. Full frame of Y=0xFF, IMG_W=320, IMG_H=240
//     -> 9600 writes, addr 0..9599, all data 0xFF;
//        buffer_ready=1 4..6 clk after vsync rise.
//  2. Alternating Y 0x80/0x7F per pixel
//     -> every byte 0xAA.
//     THRESH boundary: 0x80 -> 1, 0x7F -> 0.
//  3. vsync rises after 120 lines
//     -> frame_drop pulse, buffer_ready stays 0;
//        next full frame commits from addr 0.
//  4. In READY, drive a second full frame
//     -> zero writes.
//     Then pulse frame_read_complete
//     -> buffer_ready=0 next clk, capture resumes after next vs_rise/vs_fall.
//  5. Assert nreset mid-CAPTURE at byte 5000
//     -> outputs 0 immediately; restart waits for vs_rise;
//        next frame writes 9600 bytes from addr 0.
//  6. With FRAME_STATS_EN, frame with the left 160 px of each line 0xFF, rest 0x00
//     -> white_count=38400.
//     242 lines sent
//     -> still exactly 9600 writes, last addr 9599.

Source files
------------

// File: rtl/camera_frame_writer.sv
// DVP camera capture: binarizes the Y channel, packs 8 px/byte MSB-first and writes one frame to SPRAM.
// Optional `FRAME_STATS_EN adds white_count (1-bits written in the last committed frame).
`timescale 1ns / 1ps

module camera_frame_writer #(
   parameter int unsigned IMG_W  = 320,
   parameter int unsigned IMG_H  = 240,
   parameter logic [7:0]  THRESH = 8'd128,
   parameter int unsigned BYTES  = IMG_W * IMG_H / 8
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        cam_pclk,
   input  logic        cam_href,
   input  logic        cam_vsync,
   input  logic [7:0]  cam_data,
   output logic [16:0] spram_wr_addr,
   output logic [7:0]  spram_wr_data,
   output logic        spram_wr_en,
   output logic        buffer_ready,
   input  logic        frame_read_complete,
`ifdef FRAME_STATS_EN
   output logic [16:0] white_count,
`endif
   output logic        frame_drop
);

   localparam logic [16:0] BytesW = 17'(BYTES);

   typedef enum logic [1:0] {StWaitVs, StWaitStart, StCapture, StReady} state_e;

   state_e      state_q;
   logic [2:0]  pclk_sr, href_sr, vs_sr;
   logic [7:0]  data_s1, data_s2;
   logic [7:0]  pack_q;
   logic [2:0]  bit_cnt_q;
   logic [16:0] byte_cnt_q;
   logic        phase_q;
   logic        wr_pend_q;
`ifdef FRAME_STATS_EN
   logic [16:0] white_cnt_q;
`endif

   // Two sync flops then one history flop; data shares the pclk delay so samples line up.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pclk_sr <= '0;
         href_sr <= '0;
         vs_sr   <= '0;
         data_s1 <= '0;
         data_s2 <= '0;
      end else begin
         pclk_sr <= {pclk_sr[1:0], cam_pclk};
         href_sr <= {href_sr[1:0], cam_href};
         vs_sr   <= {vs_sr[1:0], cam_vsync};
         data_s1 <= cam_data;
         data_s2 <= data_s1;
      end
   end

   logic       pclk_rise, href_rise, vs_rise, vs_fall, href_lvl;
   logic       y_sample, y_bit;
   logic [7:0] pack_next;

   always_comb begin
      pclk_rise = pclk_sr[1] & ~pclk_sr[2];
      href_rise = href_sr[1] & ~href_sr[2];
      vs_rise   = vs_sr[1] & ~vs_sr[2];
      vs_fall   = ~vs_sr[1] & vs_sr[2];
      href_lvl  = href_sr[1];
      // A sample coinciding with href rising is the first Y byte of the line.
      y_sample  = pclk_rise & href_lvl & (href_rise | ~phase_q);
      y_bit     = (data_s2 >= THRESH);
      pack_next = {pack_q[6:0], y_bit};
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q       <= StWaitVs;
         pack_q        <= '0;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         phase_q       <= 1'b0;
         wr_pend_q     <= 1'b0;
         spram_wr_addr <= '0;
         spram_wr_data <= '0;
         spram_wr_en   <= 1'b0;
         buffer_ready  <= 1'b0;
         frame_drop    <= 1'b0;
`ifdef FRAME_STATS_EN
         white_cnt_q   <= '0;
         white_count   <= '0;
`endif
      end else begin
         spram_wr_en <= wr_pend_q;
         wr_pend_q   <= 1'b0;
         frame_drop  <= 1'b0;
         unique case (state_q)
            StWaitVs: begin
               if (vs_rise) state_q <= StWaitStart;
            end
            StWaitStart: begin
               if (vs_fall) begin
                  state_q    <= StCapture;
                  byte_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  phase_q    <= 1'b0;
`ifdef FRAME_STATS_EN
                  white_cnt_q <= '0;
`endif
               end
            end
            StCapture: begin
               if (vs_rise) begin
                  if (byte_cnt_q == BytesW) begin
                     state_q <= StReady;
`ifdef FRAME_STATS_EN
                     white_count <= white_cnt_q;
`endif
                  end else begin
                     frame_drop <= 1'b1;
                     state_q    <= StWaitStart;
                  end
               end else begin
                  if (pclk_rise && href_lvl) phase_q <= href_rise ? 1'b1 : ~phase_q;
                  else if (href_rise)        phase_q <= 1'b0;
                  if (y_sample) begin
                     pack_q    <= pack_next;
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7 && byte_cnt_q < BytesW) begin
                        wr_pend_q     <= 1'b1;
                        spram_wr_addr <= byte_cnt_q;
                        spram_wr_data <= pack_next;
                        byte_cnt_q    <= byte_cnt_q + 17'd1;
`ifdef FRAME_STATS_EN
                        white_cnt_q   <= white_cnt_q + 17'($countones(pack_next));
`endif
                     end
                  end
               end
            end
            StReady: begin
               if (frame_read_complete) begin
                  buffer_ready <= 1'b0;
                  state_q      <= StWaitVs;
               end else begin
                  buffer_ready <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer on a reduced 16x4 frame (8 packed bytes).
`timescale 1ns / 1ps

module tb_camera_frame_writer;

   localparam int W   = 16;
   localparam int H   = 4;
   localparam int NB  = W * H / 8;
   localparam int BPL = W / 8;

   logic        clk = 1'b0, nreset = 1'b0;
   logic        cam_pclk = 1'b0, cam_href = 1'b0, cam_vsync = 1'b0;
   logic [7:0]  cam_data = 8'h00;
   logic        frc = 1'b0;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_en, buffer_ready, frame_drop;
`ifdef FRAME_STATS_EN
   logic [16:0] white_count;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   camera_frame_writer #(.IMG_W(W), .IMG_H(H), .THRESH(8'd128)) dut (
      .clk                 (clk),
      .nreset              (nreset),
      .cam_pclk            (cam_pclk),
      .cam_href            (cam_href),
      .cam_vsync           (cam_vsync),
      .cam_data            (cam_data),
      .spram_wr_addr       (wr_addr),
      .spram_wr_data       (wr_data),
      .spram_wr_en         (wr_en),
      .buffer_ready        (buffer_ready),
      .frame_read_complete (frc),
`ifdef FRAME_STATS_EN
      .white_count         (white_count),
`endif
      .frame_drop          (frame_drop)
   );

   // Write / drop logger, sampled on the inactive edge.
   int         wr_total   = 0;
   int         drop_total = 0;
   logic [16:0] log_addr [0:1023];
   logic [7:0]  log_data [0:1023];

   always @(negedge clk) begin
      if (wr_en && wr_total < 1024) begin
         log_addr[wr_total] = wr_addr;
         log_data[wr_total] = wr_data;
         wr_total++;
      end
      if (frame_drop) drop_total++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] y_of(input int mode, input int x);
      case (mode)
         0:       return 8'hFF;
         1:       return (x % 2 == 0) ? 8'h80 : 8'h7F;
         default: return (x < W / 2) ? 8'hFF : 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] exp_byte(input int mode, input int idx);
      logic [7:0] r;
      int xb;
      xb = (idx % BPL) * 8;
      for (int b = 0; b < 8; b++) r[7-b] = (y_of(mode, xb + b) >= 8'd128);
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] d);
      cam_data = d;
      #31 cam_pclk = 1'b1;
      #31 cam_pclk = 1'b0;
   endtask

   // Chroma is the opposite class of Y so a phase slip corrupts the packed data.
   task automatic send_lines(input int mode, input int n);
      logic [7:0] y;
      for (int l = 0; l < n; l++) begin
         cam_href = 1'b1;
         for (int x = 0; x < W; x++) begin
            y = y_of(mode, x);
            send_byte(y);
            send_byte((y >= 8'd128) ? 8'h00 : 8'hFF);
         end
         cam_href = 1'b0;
         for (int i = 0; i < 4; i++) send_byte(8'h00);
      end
   endtask

   task automatic frame_start();
      cam_vsync = 1'b0;
      repeat (8) @(posedge clk);
      cam_vsync = 1'b1;
      repeat (10) @(posedge clk);
      cam_vsync = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic vs_fall_only();
      cam_vsync = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic frame_end(output int lat);
      @(posedge clk);
      #1 cam_vsync = 1'b1;
      lat = 0;
      while (buffer_ready !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic check_frame(input string tag, input int base, input int mode);
      check({tag, " write count"}, wr_total - base, NB);
      for (int i = 0; i < NB; i++) begin
         check($sformatf("%s addr[%0d]", tag, i), {15'd0, log_addr[base+i]}, i);
         check($sformatf("%s data[%0d]", tag, i), {24'd0, log_data[base+i]}, {24'd0, exp_byte(mode, i)});
      end
   endtask

   task automatic pulse_frc();
      check("ready before read complete", buffer_ready, 1);
      @(posedge clk);
      #1 frc = 1'b1;
      @(posedge clk);
      #1 frc = 1'b0;
      check("ready cleared after read complete", buffer_ready, 0);
   endtask

   int base, lat;

   initial begin
      #23;
      check("reset wr_en", wr_en, 0);
      check("reset wr_addr", wr_addr, 0);
      check("reset wr_data", wr_data, 0);
      check("reset buffer_ready", buffer_ready, 0);
      check("reset frame_drop", frame_drop, 0);
`ifdef FRAME_STATS_EN
      check("reset white_count", white_count, 0);
`endif
      @(posedge clk);
      #1 nreset = 1'b1;
      repeat (5) @(posedge clk);

      // Full white frame
      base = wr_total;
      frame_start();
      send_lines(0, H);
      frame_end(lat);
      check("t1 ready latency 4..6", (lat >= 4 && lat <= 6), 1);
      check_frame("t1", base, 0);
      check("t1 no drop", drop_total, 0);

      // A frame arriving while READY is ignored
      base = wr_total;
      frame_start();
      send_lines(1, H);
      frame_end(lat);
      check("t4 writes while ready", wr_total - base, 0);
      pulse_frc();

      // Threshold boundary 0x80/0x7F
      base = wr_total;
      frame_start();
      send_lines(1, H);
      frame_end(lat);
      check_frame("t2", base, 1);
      pulse_frc();

      // Short frame dropped, then recovery
      base = wr_total;
      frame_start();
      send_lines(0, H / 2);
      frame_end(lat);
      check("t3 drop pulse count", drop_total, 1);
      check("t3 ready stays low", buffer_ready, 0);
      check("t3 partial writes", wr_total - base, NB / 2);
      base = wr_total;
      vs_fall_only();
      send_lines(0, H);
      frame_end(lat);
      check_frame("t3 recovery", base, 0);
      check("t3 single drop", drop_total, 1);
      pulse_frc();

      // Reset mid-capture
      frame_start();
      send_lines(0, H / 2);
      #7 nreset = 1'b0;
      #1;
      check("t5 reset wr_en", wr_en, 0);
      check("t5 reset wr_addr", wr_addr, 0);
      check("t5 reset wr_data", wr_data, 0);
      check("t5 reset ready", buffer_ready, 0);
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      base = wr_total;
      send_lines(0, H);
      frame_end(lat);
      check("t5 no capture before vs_rise", wr_total - base, 0);
      check("t5 not ready", buffer_ready, 0);
      base = wr_total;
      vs_fall_only();
      send_lines(0, H);
      frame_end(lat);
      check_frame("t5 restart", base, 0);
      pulse_frc();

      // Left half white, two extra lines beyond the frame
      base = wr_total;
      frame_start();
      send_lines(2, H + 2);
      frame_end(lat);
      check_frame("t6", base, 2);
`ifdef FRAME_STATS_EN
      check("t6 white_count", white_count, W / 2 * H);
`endif
      pulse_frc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
